// File: rtl/key_cmd_pkg.sv
// Shared types and defaults for the push-button conditioner and its command sequencer.
// Defaults assume a 50 MHz clk: 20 ms debounce, 500 ms repeat delay, 100 ms repeat rate.
package key_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } cmd_state_e;

   localparam int unsigned N_KEYS_DEF          = 4;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int unsigned REPEAT_DELAY_DEF    = 25000000;
   localparam int unsigned REPEAT_RATE_DEF     = 5000000;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, stability counter and registered press/release strobes.
// key_level moves exactly 2 + DEBOUNCE_CYCLES cycles after a clean key_n edge.
module key_debounce
   import key_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int unsigned       CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          synced;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;
   logic          release_q, release_d;

   // Raw key is active low, so the synchroniser idles at 1 (released).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         stable_q  <= 1'b0;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= key_n;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign synced = ~sync2_q;

   // Any sample that agrees with the accepted level restarts the count.
   always_comb begin
      stable_d  = stable_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (synced != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d  = synced;
            press_d   = synced;
            release_d = ~synced;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign key_level     = stable_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule

// File: rtl/key_cmd_decoder.sv
// Debounces N active-low keys and turns a lone held key into command strobes with auto-repeat.
// cmd_valid rises one cycle after the triggering press_pulse; any other key activity cancels repeat.
module key_cmd_decoder
   import key_cmd_pkg::*;
#(
   parameter int unsigned N_KEYS          = N_KEYS_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_KEYS-1:0]         key_n,
   output logic [N_KEYS-1:0]         key_level,
   output logic [N_KEYS-1:0]         press_pulse,
   output logic [N_KEYS-1:0]         release_pulse,
   output logic                      multi_key,
   output logic                      cmd_valid,
   output logic [$clog2(N_KEYS)-1:0] cmd_idx
);

   localparam int unsigned   IW         = $clog2(N_KEYS);
   localparam int unsigned   PW         = cnt_width(N_KEYS + 1);
   localparam int unsigned   TW         = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));
   localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE - 1);

   cmd_state_e      state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            cmd_valid_q, cmd_valid_d;
   logic [IW-1:0]   cmd_idx_q, cmd_idx_d;
   logic [PW-1:0]   held_cnt;
   logic            one_held;
   logic            press_hit;
   logic [IW-1:0]   press_idx;
   logic            abort;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk          (clk),
         .reset        (reset),
         .key_n        (key_n[g]),
         .key_level    (key_level[g]),
         .press_pulse  (press_pulse[g]),
         .release_pulse(release_pulse[g])
      );
   end

   always_comb begin
      held_cnt  = '0;
      press_hit = 1'b0;
      press_idx = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         held_cnt = held_cnt + PW'(key_level[i]);
         if (press_pulse[i] && key_level[i]) begin
            press_hit = 1'b1;
            press_idx = IW'(i);
         end
      end
   end

   assign one_held = (held_cnt == PW'(1));
   assign abort    = !key_level[cmd_idx_q] || !one_held;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         cmd_valid_q <= 1'b0;
         cmd_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_idx_q   <= cmd_idx_d;
      end
   end

   // Abort is tested before expiry so a lost key never produces a late strobe.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      cmd_valid_d = 1'b0;
      cmd_idx_d   = cmd_idx_q;
      case (state_q)
         IDLE: begin
            if (press_hit && one_held) begin
               cmd_valid_d = 1'b1;
               cmd_idx_d   = press_idx;
               timer_d     = DELAY_LOAD;
               state_d     = DELAY;
            end
         end
         DELAY, REPEAT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (timer_q == '0) begin
               cmd_valid_d = 1'b1;
               timer_d     = RATE_LOAD;
               state_d     = REPEAT;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_valid = cmd_valid_q;
      cmd_idx   = cmd_idx_q;
      multi_key = (held_cnt >= PW'(2));
   end

endmodule
